// File: rtl/div_iterative.sv
// div_iterative: multicycle signed restoring divider, one shift-subtract step per clock.
// Optional macro DIV_EARLY_ZERO_EN: divide-by-zero finishes after a single step instead of WIDTH.
module div_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic             ovf;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_sh;
    logic             take;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             finish;

    // one restoring step: shift {R,Q}, trial-subtract the divisor in WIDTH+1 bits
    always_comb begin
        r_sh  = {rem, quo[WIDTH-1]};
        take  = r_sh >= {1'b0, dvs};
        r_nxt = take ? WIDTH'(r_sh - {1'b0, dvs}) : r_sh[WIDTH-1:0];
        q_nxt = {quo[WIDTH-2:0], take};
    end

`ifdef DIV_EARLY_ZERO_EN
    assign finish = (cnt == LAST) || div_zero;
`else
    assign finish = (cnt == LAST);
`endif

    // control FSM and datapath; a start strobe wins in every state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            a_raw          <= '0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            div_zero       <= 1'b0;
            ovf            <= 1'b0;
            cnt            <= '0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_DIV) begin
            state          <= RUN;
            busy           <= 1'b1;
            data_resultRDY <= 1'b0;
            quo            <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            dvs            <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            a_raw          <= data_operandA;
            sign_a         <= data_operandA[WIDTH-1];
            sign_b         <= data_operandB[WIDTH-1];
            div_zero       <= data_operandB == '0;
            ovf            <= (data_operandA == MIN) && (data_operandB == '1);
            rem            <= '0;
            cnt            <= '0;
        end else if (state == RUN) begin
            rem <= r_nxt;
            quo <= q_nxt;
            cnt <= cnt + 1'b1;
            if (finish) begin
                state          <= DONE;
                busy           <= 1'b0;
                data_resultRDY <= 1'b1;
                data_result    <= div_zero ? '0 : (sign_a ^ sign_b) ? -q_nxt : q_nxt;
                data_remainder <= div_zero ? a_raw : sign_a ? -r_nxt : r_nxt;
                data_exception <= div_zero | ovf;
            end
        end else begin
            state          <= IDLE;
            data_resultRDY <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_iterative.sv
// tb_div_iterative: scoreboard bench for div_iterative against a signed-arithmetic reference model.
module tb_div_iterative;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;
`ifdef DIV_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           cyc;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   rdy_count = 0;
    int   compared = 0;
    int   mismatched = 0;

    div_iterative #(.WIDTH(W)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ctrl_DIV(ctrl_DIV),
        .data_operandA(a),
        .data_operandB(b),
        .data_result(data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic signed [W-1:0] sx = x;
        logic signed [W-1:0] sy = y;
        e.cyc = 0;
        if (y == '0) begin
            e.q = '0;
            e.r = x;
            e.e = 1'b1;
        end else if (x == MIN && y == '1) begin
            e.q = MIN;
            e.r = '0;
            e.e = 1'b1;
        end else begin
            e.q = sx / sy;
            e.r = sx % sy;
            e.e = 1'b0;
        end
        return e;
    endfunction

    // called at a falling edge; the start is sampled on the following rising edge
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e = model(x, y);
        e.cyc = cyc + 1 + ((EARLY && y == '0) ? 1 : W);
        sb.push_back(e);
        a = x;
        b = y;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
        check("busy_after_start", W'(busy), W'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * W + 10 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL wait_idle: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    // monitor: pops the scoreboard on each ready pulse
    always @(negedge clock) begin
        if (reset_n) begin
            if (data_resultRDY) begin
                rdy_count++;
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rdy: got ready with result %h, expected no ready", data_result);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", data_result, mon_e.q);
                    check("remainder", data_remainder, mon_e.r);
                    check("exception", W'(data_exception), W'(mon_e.e));
                    check("ready_cycle", W'(cyc), W'(mon_e.cyc));
                    check("busy_at_rdy", W'(busy), W'(0));
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                compared++;
                mismatched++;
                $display("FAIL ready_timeout: no ready by cycle %0d, expected at %0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] da[12];
        logic [W-1:0] db[12];
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           seen;
        da = '{100, -100, 100, 5, MIN, MIN, 0, -7, 7, MIN, 32'h7fff_ffff, -1};
        db = '{7, 7, -7, 0, '1, 1, 5, 0, 100, MIN, MIN, 3};
        #1 reset_n = 1'b0;
        #1;
        check("reset_result", data_result, '0);
        check("reset_remainder", data_remainder, '0);
        check("reset_exception", W'(data_exception), W'(0));
        check("reset_rdy", W'(data_resultRDY), W'(0));
        check("reset_busy", W'(busy), W'(0));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            issue(da[i], db[i]);
            wait_idle();
        end
        issue(100, 7);
        repeat (9) @(negedge clock);
        void'(sb.pop_back());
        issue(9, 3);
        wait_idle();
        issue(1000, -33);
        for (int i = 0; i < 2 * W + 10; i++) begin
            @(negedge clock);
            if (data_resultRDY) break;
        end
        issue(-77, 5);
        wait_idle();
        issue(100, 7);
        repeat (14) @(negedge clock);
        #2 reset_n = 1'b0;
        sb.delete();
        seen = rdy_count;
        #1;
        check("async_reset_result", data_result, '0);
        check("async_reset_remainder", data_remainder, '0);
        check("async_reset_busy", W'(busy), W'(0));
        check("async_reset_rdy", W'(data_resultRDY), W'(0));
        @(negedge clock);
        reset_n = 1'b1;
        repeat (W + 10) @(negedge clock);
        check("no_rdy_after_reset", W'(rdy_count), W'(seen));
        issue(9, 3);
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin x = $urandom; y = $urandom; end
                1: begin x = $urandom_range(0, 2000) - 1000; y = $urandom_range(0, 30) - 15; end
                2: begin x = $urandom; y = '0; end
                3: begin x = MIN; y = $urandom_range(0, 1) != 0 ? '1 : $urandom; end
                default: begin x = $urandom; y = $urandom >> $urandom_range(0, 31); end
            endcase
            issue(x, y);
            wait_idle();
        end
        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/div_iterative.md
# div_iterative

Multicycle signed integer divider for the multdiv unit, the counterpart to the iterative multiplier. It takes a one-cycle start strobe with two operands and computes quotient and remainder with one restoring shift-subtract step per clock. It raises a one-cycle ready pulse and flags exceptions to the processor's multdiv stall logic.

## Interface
- WIDTH, 32, operand/result width in bits; latency scales with it
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_DIV  in  1  start strobe; operands sampled on the same edge
- data_operandA  in  WIDTH  dividend, two's complement
- data_operandB  in  WIDTH  divisor, two's complement
- data_result  out  WIDTH  quotient, registered
- data_remainder  out  WIDTH  remainder, registered
- data_exception  out  1  divide-by-zero or overflow, valid with data_resultRDY
- data_resultRDY  out  1  one-cycle pulse: results valid
- busy  out  1  high while a division is in progress

## Operation
- States: IDLE, RUN, DONE.
- **Reset:** state IDLE. data_result, data_remainder, data_exception, data_resultRDY and busy are 0. Step counter and working registers are 0.
- **Start, ctrl_DIV=1 in any state:**
  - latch |A| into the quotient shift register, |B| into the divisor register, and sign(A), sign(B);
  - clear the partial remainder R (WIDTH+1 bits) and counter;
  - go to RUN with busy=1.
- **Start during RUN:** aborts the current division and restarts with the new operands. No ready pulse is emitted for the aborted one.
- **RUN step, one per edge:**
  - shift {R,Q} left 1;
  - trial T = R − divisor;
  - if T ≥ 0, R=T and Q[0]=1, else Q[0]=0;
  - increment counter.
- **Final step (counter = WIDTH−1), same edge:**
  - data_result = Q, negated if sign(A)≠sign(B);
  - data_remainder = R, negated if sign(A)=1 (truncating division; remainder takes dividend's sign);
  - data_resultRDY=1, busy=0, go to DONE.
- **DONE:** lasts one cycle, then returns to IDLE with data_resultRDY=0. Result outputs hold until the next completion.
- Magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), representable unsigned. Datapath arithmetic is unsigned WIDTH+1 bits.
- **Divide by zero (B=0):** data_result=0, data_remainder=A, data_exception=1.
- **Overflow (A=−2^(WIDTH−1), B=−1):** data_result=0x80000000 (wrapped), data_remainder=0, data_exception=1.
- Otherwise data_exception=0 with each ready pulse.

## Timing
- Start sampled at edge E0. Steps occur on E1..E_WIDTH.
- data_resultRDY is high for exactly the cycle following E_WIDTH (E32 for WIDTH=32) and clears at the next edge.
- busy is high from E0 until E_WIDTH.
- Back-to-back: ctrl_DIV in the DONE cycle starts a new division. The ready pulse still occurs in that cycle.
- reset_n low at any time clears immediately, without waiting for the clock. An in-flight division is lost and no ready pulse follows.

## Configuration
- DIV_EARLY_ZERO_EN defined:
  - B=0 is detected at the start edge;
  - state goes straight to DONE at E1 with data_result=0, data_remainder=A, data_exception=1;
  - data_resultRDY is high in the cycle after E1.
- Undefined: divide by zero runs the full WIDTH-cycle sequence and reports at the normal ready time. All other behaviour is identical.

## Test plan
- 100 / 7 → after 32 edges, one-cycle RDY; result 14, remainder 2, exception 0.
- −100 / 7 → result −14 (0xFFFFFFF2), remainder −2; 100 / −7 → result −14, remainder 2.
- 5 / 0 → result 0, remainder 5, exception 1. RDY after E1 with DIV_EARLY_ZERO_EN, after E32 without.
- 0x80000000 / 0xFFFFFFFF → result 0x80000000, remainder 0, exception 1. 0x80000000 / 1 → result 0x80000000, exception 0.
- Start 100/7, restart with 9/3 ten cycles later → exactly one RDY, 32 edges after the second start; result 3, remainder 0.
- Start 100/7, pulse reset_n low at cycle 15 → outputs 0 immediately, busy 0, no RDY. The next division completes normally.
